bram1_result_reader: RTL
========================

Name: bram1_result_reader

Overview:
- Reads accumulated results back out of BRAM1. This is the consumer end of the 64-bit rows written by the accumulate datapath.
- Each row holds four 16-bit results. The block reads run_count_i rows starting at address 0 and unpacks each row into 16-bit words.
- Words are streamed on a valid/ready master port, so a host-side DMA or UART packer can drain results with backpressure.

Parameters:
- CNT_BIT, 31, width of run_count_i and the internal row counter.
- DWIDTH, 64, BRAM1 row width.
- AWIDTH, 8, BRAM1 address width.
- OUT_WIDTH, 16, width of one result word; DWIDTH/OUT_WIDTH = 4 lanes per row.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_run_i  in  1  start pulse; sampled only in IDLE
- run_count_i  in  CNT_BIT  number of rows to read; sampled with start_run_i
- q_b1_i  in  DWIDTH  BRAM1 read data; valid 1 cycle after a ce_b1_o=1 read
- addr_b1_o  out  AWIDTH  BRAM1 address
- ce_b1_o  out  1  BRAM1 chip enable
- we_b1_o  out  1  BRAM1 write enable; constant 0
- d_b1_o  out  DWIDTH  BRAM1 write data; constant 0
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  OUT_WIDTH  output result word
- m_last_o  out  1  high with the final word of the run
- idle_o / run_o / done_o  out  1 each  one-hot FSM state

Behaviour:
- Reset values: idle_o=1; run_o, done_o, ce_b1_o, m_valid_o and m_last_o =0; addr_b1_o=0; m_data_o=0.
- Reset mid-run: reset returns to IDLE in the next cycle. Any in-flight read is discarded and buffered words are dropped.
- FSM states and transitions:
  - IDLE -> RUN on start_run_i=1 with run_count_i!=0. The count is latched at that edge.
  - IDLE -> DONE on start_run_i=1 with run_count_i=0. No reads are issued and no words are emitted.
  - RUN -> DONE in the cycle after the handshake (m_valid_o && m_ready_i) of the word with m_last_o=1.
  - DONE -> IDLE unconditionally. DONE lasts exactly 1 cycle.
  - start_run_i outside IDLE is ignored.
- Read issue:
  - In RUN, ce_b1_o=1 with addr_b1_o=row_idx[AWIDTH-1:0] when rows_issued < count and a buffer slot is free, counting the in-flight read.
  - row_idx increments on each issued read.
  - Addresses wrap modulo 2^AWIDTH when count > 2^AWIDTH. That case is legal, and rows are re-read.
- Row buffer:
  - 2-entry FIFO captures q_b1_i one cycle after each issued read.
  - Reads are never issued when occupancy plus in-flight would exceed 2, so no read data is ever lost.
- Unpack:
  - Lane index 0..3 walks the head row. m_data_o = row[lane*16+15 : lane*16], so lane 0 (bits 15:0) goes first.
  - Lane advances on each handshake; after lane 3 the head row is popped.
- Handshake rules:
  - m_valid_o, once asserted, holds with m_data_o and m_last_o stable until m_ready_i=1.
  - m_valid_o never depends combinationally on m_ready_i.
- m_last_o = 1 only for lane 3 of row count-1.
- Throughput: with m_ready_i held at 1, one word per cycle after the initial latency.
- Latency: first m_valid_o is asserted no later than 3 cycles after the start_run_i edge.
- A total of 4*count words are emitted per run.

Optional Feature:
- Macro: BRAM1_READER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt_o [31:0], counting cycles in RUN with m_valid_o=1 and m_ready_i=0.
  - Cleared on reset and on the IDLE->RUN transition, held in DONE/IDLE, saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter do not exist, and behaviour is otherwise identical.

Test Plan:
- Preload BRAM1[0]=64'h0004_0003_0002_0001; start with run_count_i=1 and m_ready_i=1 -> words 1,2,3,4 on consecutive cycles, m_last_o only on 4; done_o pulses 1 cycle, then idle_o=1.
- run_count_i=3 with rows 0..2 preloaded and m_ready_i toggling 1010... -> 12 words in address/lane order, none dropped or duplicated, data stable while stalled; with stall_cnt_en, stall_cnt_o=number of stalled valid cycles.
- run_count_i=0 -> no ce_b1_o, no m_valid_o; done_o high in the cycle after start, then IDLE.
- m_ready_i=0 for 20 cycles after start, run_count_i=4 -> ce_b1_o is asserted at most 2 times plus in-flight (≤3 reads) until ready returns; afterwards 16 words are emitted correctly.
- run_count_i=258 -> addr_b1_o sequence 0..255,0,1; 1032 words emitted; m_last_o on lane 3 of row index 257.
- Assert reset for 1 cycle mid-run with m_valid_o=1 -> next cycle idle_o=1 and m_valid_o=0; a new start with run_count_i=1 replays row 0 correctly.

Source files
------------

// File: rtl/bram1_result_reader.sv
// ---------------------------------------------------------------------------
// bram1_result_reader
//
// Drains accumulated results from BRAM1. The block reads run_count_i rows,
// starting at address 0. Each row is DWIDTH bits wide and holds
// DWIDTH/OUT_WIDTH result words. Every row is split into its words, and the
// words leave on a valid/ready master port with lane 0 (the low bits) first.
//
// Optional build macro: BRAM1_READER_STALL_CNT_EN
//   When this macro is defined, the block adds stall_cnt_o. That output counts
//   the RUN cycles in which a word was offered (m_valid_o=1) but not accepted
//   (m_ready_i=0).
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start_run_i       start pulse, sampled only in IDLE
//   run_count_i       number of rows to read, latched together with the start
//   q_b1_i            BRAM1 read data, valid one cycle after a ce_b1_o read
//   addr_b1_o         BRAM1 row address (wraps modulo 2^AWIDTH)
//   ce_b1_o           BRAM1 chip enable (read strobe)
//   we_b1_o, d_b1_o   BRAM1 write port, tied off (this block only reads)
//   m_valid_o         output word valid
//   m_ready_i         downstream ready
//   m_data_o          output word
//   m_last_o          set with the final word of the run
//   idle_o/run_o/done_o  one-hot FSM state
//   stall_cnt_o       (optional) count of stalled valid cycles, saturating
// ---------------------------------------------------------------------------
module bram1_result_reader #(
    parameter int CNT_BIT   = 31,
    parameter int DWIDTH    = 64,
    parameter int AWIDTH    = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_run_i,
    input  logic [CNT_BIT-1:0]   run_count_i,
    input  logic [DWIDTH-1:0]    q_b1_i,
    output logic [AWIDTH-1:0]    addr_b1_o,
    output logic                 ce_b1_o,
    output logic                 we_b1_o,
    output logic [DWIDTH-1:0]    d_b1_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [OUT_WIDTH-1:0] m_data_o,
    output logic                 m_last_o,
    output logic                 idle_o,
    output logic                 run_o,
    output logic                 done_o
`ifdef BRAM1_READER_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    localparam int LANES  = DWIDTH / OUT_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_n;

    // Run control
    logic [CNT_BIT-1:0] count_q;
    logic [CNT_BIT-1:0] rows_issued_q;   // also the row index; its low bits form the address
    logic [CNT_BIT-1:0] rows_popped_q;   // the row index of the current FIFO head
    logic [LANE_W-1:0]  lane_q;

    // Two-entry row buffer
    logic [DWIDTH-1:0]  row_buf [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         occ_q;

    // Set when a read was issued in the previous cycle, so that q_b1_i is valid now.
    logic               rd_vld_p1;

    logic start_accept;
    logic slot_free;
    logic issue;
    logic push;
    logic hs;
    logic pop;
    logic lane_last;
    logic [DWIDTH-1:0] head_row;

    assign start_accept = (state_q == S_IDLE) && start_run_i;

    // A slot is free only when the stored rows plus the read in flight stay
    // below two. A pop in the same cycle is not counted, so the buffer can
    // never overflow. One read every four words still keeps the output stream
    // running without gaps.
    assign slot_free = (occ_q == 2'd0) || ((occ_q == 2'd1) && !rd_vld_p1);
    assign issue     = (state_q == S_RUN) && (rows_issued_q < count_q) && slot_free;
    assign push      = rd_vld_p1;

    assign head_row  = row_buf[rd_ptr_q];
    assign lane_last = (lane_q == LANE_LAST);
    assign hs        = m_valid_o && m_ready_i;
    assign pop       = hs && lane_last;

    assign ce_b1_o   = issue;
    assign addr_b1_o = issue ? rows_issued_q[AWIDTH-1:0] : '0;
    assign we_b1_o   = 1'b0;
    assign d_b1_o    = '0;

    // m_valid_o depends only on registered state. It never looks at m_ready_i.
    assign m_valid_o = (state_q == S_RUN) && (occ_q != 2'd0);
    assign m_data_o  = m_valid_o ? head_row[lane_q*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign m_last_o  = m_valid_o && lane_last && (rows_popped_q == count_q - CNT_BIT'(1));

    assign idle_o    = (state_q == S_IDLE);
    assign run_o     = (state_q == S_RUN);
    assign done_o    = (state_q == S_DONE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_run_i) begin
                    state_n = (run_count_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (hs && m_last_o) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Read-issue stage -> capture stage (rd_vld_p1), plus buffer and lane control
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= '0;
            rows_issued_q <= '0;
            rows_popped_q <= '0;
            lane_q        <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            rd_vld_p1     <= 1'b0;
        end else if (start_accept) begin
            count_q       <= run_count_i;
            rows_issued_q <= '0;
            rows_popped_q <= '0;
            lane_q        <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            rd_vld_p1     <= 1'b0;
        end else begin
            rd_vld_p1 <= issue;
            if (issue) begin
                rows_issued_q <= rows_issued_q + CNT_BIT'(1);
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (hs) begin
                if (lane_last) begin
                    lane_q        <= '0;
                    rd_ptr_q      <= ~rd_ptr_q;
                    rows_popped_q <= rows_popped_q + CNT_BIT'(1);
                end else begin
                    lane_q <= lane_q + LANE_W'(1);
                end
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Row data capture (data path, no reset)
    always_ff @(posedge clk) begin
        if (rd_vld_p1) begin
            row_buf[wr_ptr_q] <= q_b1_i;
        end
    end

`ifdef BRAM1_READER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_o <= '0;
        end else if (start_accept && (run_count_i != '0)) begin
            stall_cnt_o <= '0;
        end else if ((state_q == S_RUN) && m_valid_o && !m_ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
